// File: rtl/mips_pkg.sv
// Shared types for the MIPS execute/memory pipeline: branch encodings,
// the execute-to-memory payload and the skid-buffer state.
package mips_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLTZ = 3'b011,
    BR_BGEZ = 3'b100,
    BR_BLEZ = 3'b101,
    BR_BGTZ = 3'b110,
    BR_J    = 3'b111
  } branch_op_t;

  typedef struct packed {
    logic [31:0] y;
    logic [31:0] store_data;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } ex_mem_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// Execute->memory stage bus: upstream handshake/payload, downstream
// handshake/payload, and the redirect/exception side-band pulses.
interface ex_mem_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_y;
  logic        in_z;
  logic        in_v;
  logic        in_n;
  logic [31:0] in_store_data;
  logic [4:0]  in_dest;
  logic        in_reg_write;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [2:0]  in_branch_op;
  logic [31:0] in_branch_target;
  logic [31:0] in_pc;
  logic        in_trap_en;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [31:0] out_store_data;
  logic [4:0]  out_dest;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc_valid;
  logic [31:0] exc_pc;

  // Driver side: execute stage + memory stage + pipeline control.
  modport master (
    output in_valid, in_y, in_z, in_v, in_n, in_store_data, in_dest,
           in_reg_write, in_mem_read, in_mem_write, in_branch_op,
           in_branch_target, in_pc, in_trap_en, flush, out_ready,
    input  in_ready, out_valid, out_y, out_store_data, out_dest,
           out_reg_write, out_mem_read, out_mem_write,
           redirect_valid, redirect_pc, exc_valid, exc_pc
  );

  // The stage itself.
  modport slave (
    input  in_valid, in_y, in_z, in_v, in_n, in_store_data, in_dest,
           in_reg_write, in_mem_read, in_mem_write, in_branch_op,
           in_branch_target, in_pc, in_trap_en, flush, out_ready,
    output in_ready, out_valid, out_y, out_store_data, out_dest,
           out_reg_write, out_mem_read, out_mem_write,
           redirect_valid, redirect_pc, exc_valid, exc_pc
  );
endinterface

// File: rtl/ex_mem_stage_branch_resolve.sv
// Combinational branch condition evaluation from ALU z/n flags.
module branch_resolve
  import mips_pkg::*;
(
  input  branch_op_t branch_op,
  input  logic       z,
  input  logic       n,
  output logic       taken
);
  always_comb begin
    taken = 1'b0;
    unique case (branch_op)
      BR_NONE: taken = 1'b0;
      BR_BEQ:  taken = z;
      BR_BNE:  taken = ~z;
      BR_BLTZ: taken = n;
      BR_BGEZ: taken = ~n;
      BR_BLEZ: taken = n | z;
      BR_BGTZ: taken = ~n & ~z;
      BR_J:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/ex_mem_stage.sv
// Execute->memory stage: two-entry skid buffer, branch redirect and
// optional signed-overflow trap (enable with `define OVERFLOW_TRAP_EN).
module ex_mem_stage
  import mips_pkg::*;
(
  input logic          clk,
  input logic          reset,
  ex_mem_stage_if.slave bus
);
  buf_state_t  state, state_nxt;
  ex_mem_t     head, skid, in_ent;
  logic        in_ready_q;
  logic        acc, xfer, squash, taken, trap;
  logic        head_ld, head_from_skid, skid_ld;
  logic        redir_q, exc_q;
  logic [31:0] redir_pc_q, exc_pc_q;

  // A redirect/exception pulse in flight means this cycle's input is on
  // the wrong path; flush overrides everything.
  assign squash = redir_q | exc_q;
  assign acc    = bus.in_valid & in_ready_q & ~squash & ~bus.flush;
  assign xfer   = (state != S_EMPTY) & bus.out_ready;

`ifdef OVERFLOW_TRAP_EN
  assign trap = bus.in_trap_en & bus.in_v;
`else
  logic unused_trap_in;
  assign unused_trap_in = bus.in_trap_en ^ bus.in_v;
  assign trap = 1'b0;
`endif

  branch_resolve u_br (
    .branch_op (branch_op_t'(bus.in_branch_op)),
    .z         (bus.in_z),
    .n         (bus.in_n),
    .taken     (taken)
  );

  always_comb begin
    in_ent            = '0;
    in_ent.y          = bus.in_y;
    in_ent.store_data = bus.in_store_data;
    in_ent.dest       = bus.in_dest;
    in_ent.reg_write  = bus.in_reg_write & ~trap;
    in_ent.mem_read   = bus.in_mem_read;
    in_ent.mem_write  = bus.in_mem_write;
  end

  always_comb begin
    state_nxt      = state;
    head_ld        = 1'b0;
    head_from_skid = 1'b0;
    skid_ld        = 1'b0;
    unique case (state)
      S_EMPTY: if (acc) begin
        state_nxt = S_ONE;
        head_ld   = 1'b1;
      end
      S_ONE: begin
        unique case ({acc, xfer})
          2'b10: begin state_nxt = S_TWO; skid_ld = 1'b1; end
          2'b01: state_nxt = S_EMPTY;
          2'b11: head_ld = 1'b1;
          default: ;
        endcase
      end
      S_TWO: if (xfer) begin
        state_nxt      = S_ONE;
        head_from_skid = 1'b1;
      end
      default: state_nxt = S_EMPTY;
    endcase
    if (bus.flush) state_nxt = S_EMPTY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_EMPTY;
      in_ready_q <= 1'b1;
      head       <= '0;
      skid       <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != S_TWO);
      if (head_ld)             head <= in_ent;
      else if (head_from_skid) head <= skid;
      if (skid_ld)             skid <= in_ent;
    end
  end

  // Trap outranks a (malformed) taken branch on the same entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
    end else if (bus.flush) begin
      redir_q    <= 1'b0;
    end else begin
      redir_q <= acc & taken & ~trap;
      if (acc & taken & ~trap) redir_pc_q <= bus.in_branch_target;
    end
  end

`ifdef OVERFLOW_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_q    <= 1'b0;
      exc_pc_q <= '0;
    end else if (bus.flush) begin
      exc_q    <= 1'b0;
    end else begin
      exc_q <= acc & trap;
      if (acc & trap) exc_pc_q <= bus.in_pc;
    end
  end
`else
  logic [31:0] unused_pc;
  assign unused_pc = bus.in_pc;
  assign exc_q     = 1'b0;
  assign exc_pc_q  = '0;
`endif

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = (state != S_EMPTY);
  assign bus.out_y          = head.y;
  assign bus.out_store_data = head.store_data;
  assign bus.out_dest       = head.dest;
  assign bus.out_reg_write  = head.reg_write;
  assign bus.out_mem_read   = head.mem_read;
  assign bus.out_mem_write  = head.mem_write;
  assign bus.redirect_valid = redir_q;
  assign bus.redirect_pc    = redir_pc_q;
  assign bus.exc_valid      = exc_q;
  assign bus.exc_pc         = exc_pc_q;
endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline stage of the MIPS core. Consumes the ALU result and its z/v/n flags, resolves branches and jumps, and optionally raises a signed-overflow trap. It holds up to two instructions in a valid/ready skid buffer so that the execute stage never sees a combinational path from memory-stage backpressure. Sits directly downstream of the ALU and directly upstream of data memory / writeback.

## Interface
Parameters:
- none; all widths are fixed (32-bit datapath, 5-bit register index).

Ports:
- clk  in  1  single clock for the block.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  block accepts; registered, never depends combinationally on out_ready.
- in_y  in  32  ALU result Y.
- in_z, in_v, in_n  in  1 each  ALU zero / overflow / negative flags.
- in_store_data  in  32  rt value for stores.
- in_dest  in  5  destination register.
- in_reg_write, in_mem_read, in_mem_write  in  1 each  control bits.
- in_branch_op  in  3  branch/jump kind.
- in_branch_target  in  32  target PC.
- in_pc  in  32  instruction PC.
- in_trap_en  in  1  instruction is a signed add/sub (add, addi, sub).
- flush  in  1  global squash.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  memory stage accepts.
- out_y, out_store_data  out  32  head entry fields.
- out_dest  out  5.
- out_reg_write, out_mem_read, out_mem_write  out  1 each.
- redirect_valid  out  1  one-cycle pulse: fetch must go to redirect_pc.
- redirect_pc  out  32.
- exc_valid  out  1  one-cycle overflow-trap pulse.
- exc_pc  out  32  PC of the trapping instruction.

## Operation
- Accept when in_valid & in_ready; transfer out when out_valid & out_ready.
- Buffer FSM: EMPTY, ONE (head only), TWO (head + skid).
  - EMPTY: accept -> ONE.
  - ONE: accept without transfer -> TWO; transfer without accept -> EMPTY; both or neither -> ONE.
  - TWO: transfer -> ONE, with skid moving to head; accept is impossible.
- in_ready = (state != TWO), registered.
- Branch resolution happens at acceptance, regardless of which slot the entry lands in. in_branch_op:
  - 000 none.
  - 001 beq: z.
  - 010 bne: !z.
  - 011 bltz: n.
  - 100 bgez: !n.
  - 101 blez: n|z.
  - 110 bgtz: !n&!z.
  - 111 j: always taken.
- Taken -> next cycle redirect_valid=1, redirect_pc=in_branch_target. The branch itself continues to out_*. There is no delay slot.
- Squash: in any cycle with redirect_valid or exc_valid high, an instruction accepted that cycle is discarded. The buffer does not change state for it.
- flush: buffer -> EMPTY next edge. Pending redirect/exc pulses are cancelled.
- Priority: reset > flush > squash > normal accept/transfer.

## Timing
- Reset values: state EMPTY; in_ready=1; out_valid=0; all out_* data=0; redirect_valid=0; redirect_pc=0; exc_valid=0; exc_pc=0.
- Latency in->out: 1 cycle when empty and out_ready=1.
- Throughput: 1 per cycle when out_ready is held at 1.
- out_* are stable while out_valid & !out_ready.
- redirect/exc pulses are exactly one cycle wide, one cycle after acceptance.
- Reset asserted mid-operation: everything returns to reset values asynchronously; the contents of both slots are lost.

## Configuration
- OVERFLOW_TRAP_EN defined: an accepted entry with in_trap_en & in_v has reg_write cleared and still flows to out_*. exc_valid pulses next cycle with exc_pc=in_pc. If the same entry is also a taken branch (not legal encoding), the trap wins and no redirect is issued.
- OVERFLOW_TRAP_EN undefined: in_v and in_trap_en are ignored; exc_valid=0 and exc_pc=0 constantly.

## Structure
- mips_pkg:
  - branch_op_t enum (BR_NONE..BR_J, 3 bits).
  - ex_mem_t struct (y, store_data, dest, reg_write, mem_read, mem_write).
- Sub-module branch_resolve: combinational; inputs branch_op, z, n; output taken.
- Head and skid slots are ex_mem_t registers.

## Test plan
- Single add, out_ready=1: in_y=0x0000_0005, dest=3 accepted at cycle 0 -> out_valid cycle 1 with out_y=5, out_dest=3; in_ready stays 1.
- Backpressure: out_ready=0, three back-to-back inputs -> first two held (state TWO), in_ready=0 at cycle 2, third not accepted. Release out_ready -> outputs in order, no loss or duplication.
- beq with z=1, target 0x0040_0020 -> redirect_valid pulse 1 cycle later with redirect_pc=0x0040_0020; input offered in that pulse cycle is dropped. Same beq with z=0 -> no pulse.
- bgtz/blez with n=0, z=0 -> bgtz taken, blez not; with n=1 -> blez taken.
- OVERFLOW_TRAP_EN: add with v=1, in_pc=0x0040_0100, reg_write=1 -> exc_valid pulse with exc_pc=0x0040_0100 and out_reg_write=0. Without the macro: exc_valid=0 and out_reg_write=1.
- flush while state TWO, followed by reset mid-stream -> out_valid=0 and in_ready=1 the next cycle; reset immediately forces all reset values.
